// File: rtl/fetch_pkg.sv
// Shared constants, instruction field positions and state/action encodings
// for the two-stage instruction fetch unit.
package fetch_pkg;

  localparam int ADDR_W  = 10;
  localparam int INSTR_W = 22;

  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OPC_HI = 21;
  localparam int OPC_LO = 18;
  localparam int DST_HI = 11;
  localparam int DST_LO = 9;
  localparam int IMM_HI = 8;
  localparam int IMM_LO = 0;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

  // What the pipeline registers do at the coming edge, already prioritised.
  typedef enum logic [2:0] {
    ACT_ADVANCE = 3'd0,
    ACT_STALL   = 3'd1,
    ACT_BRANCH  = 3'd2,
    ACT_HALT    = 3'd3,
    ACT_HOLD    = 3'd4,
    ACT_RESET   = 3'd5
  } fetch_act_e;

  function automatic logic is_halt(input logic valid, input logic [3:0] opc);
    return valid && (opc == OP_HALT);
  endfunction

endpackage

// File: rtl/fetch_pc_sel.sv
// Combinational next-PC selection: resolves reset/halt/stall/branch/advance
// priority and produces the action code plus the next fetch address.
module fetch_pc_sel
  import fetch_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic         i_pc_reset,
  input  fetch_state_e i_state,
  input  logic         i_instr_valid,
  input  logic [3:0]   i_opcode,
  input  logic         i_stall,
  input  logic         i_branch_taken,
  input  logic [PC_W-1:0] i_branch_target,
  input  logic [PC_W-1:0] i_address,
  input  logic [PC_W-1:0] i_pc_d1,
  input  logic         i_valid_d1,
  output fetch_act_e   o_act,
  output logic [PC_W-1:0] o_next_pc
);

  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    o_act     = ACT_ADVANCE;
    o_next_pc = i_address + PC_W'(1);
    if (i_pc_reset) begin
      o_act     = ACT_RESET;
      o_next_pc = '0;
    end else if (i_state == ST_HALTED) begin
      o_act     = ACT_HOLD;
      o_next_pc = i_address;
    end else if (is_halt(i_instr_valid, i_opcode)) begin
      o_act     = ACT_HALT;
      o_next_pc = i_address;
    end else if (i_stall) begin
      // Re-fetch the word that is being dropped from RAMdata, exactly once.
      o_act     = ACT_STALL;
      o_next_pc = i_valid_d1 ? i_pc_d1 : i_address;
    end else if (i_branch_taken && i_instr_valid) begin
      o_act     = ACT_BRANCH;
      o_next_pc = i_branch_target;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Two-stage instruction fetch: fetch PC -> D1 (word on RAMdata) -> IR, with
// stall replay, branch squash, sticky HALT and synchronous reset.
module instr_fetch #(
  parameter int ADDR_W  = fetch_pkg::ADDR_W,
  parameter int INSTR_W = fetch_pkg::INSTR_W
) (
  input  logic               clock,
  input  logic               PC_Reset,
  input  logic [INSTR_W-1:0] RAMdata,
  output logic [ADDR_W-1:0]  address,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  output logic [3:0]         opcode,
  output logic [2:0]         dest,
  output logic [8:0]         imm,
  output logic               halted
);

  import fetch_pkg::*;

  fetch_state_e       r_state;
  logic [ADDR_W-1:0]  r_address;
  logic [ADDR_W-1:0]  r_pc_d1;
  logic               r_valid_d1;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_instr_pc;
  logic               r_instr_valid;
  logic               r_halted;

  fetch_act_e         w_act;
  logic [ADDR_W-1:0]  w_next_pc;
  logic [3:0]         w_opcode;

  assign w_opcode = r_instr[OPC_HI:OPC_LO];

  fetch_pc_sel #(
    .PC_W (ADDR_W)
  ) u_pc_sel (
    .i_pc_reset      (PC_Reset),
    .i_state         (r_state),
    .i_instr_valid   (r_instr_valid),
    .i_opcode        (w_opcode),
    .i_stall         (stall),
    .i_branch_taken  (branch_taken),
    .i_branch_target (branch_target),
    .i_address       (r_address),
    .i_pc_d1         (r_pc_d1),
    .i_valid_d1      (r_valid_d1),
    .o_act           (w_act),
    .o_next_pc       (w_next_pc)
  );

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (PC_Reset) begin
      r_state       <= ST_RUN;
      r_address     <= '0;
      r_pc_d1       <= '0;
      r_valid_d1    <= 1'b0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      case (w_act)
        ACT_ADVANCE: begin
          r_instr       <= RAMdata;
          r_instr_pc    <= r_pc_d1;
          r_instr_valid <= r_valid_d1;
          r_pc_d1       <= r_address;
          r_valid_d1    <= 1'b1;
          r_address     <= w_next_pc;
        end
        ACT_STALL: begin
          r_address  <= w_next_pc;
          r_valid_d1 <= 1'b0;
        end
        ACT_BRANCH: begin
          // The IR word has been consumed; the word on RAMdata is wrong-path.
          r_address     <= w_next_pc;
          r_valid_d1    <= 1'b0;
          r_instr_valid <= 1'b0;
        end
        ACT_HALT: begin
          r_state       <= ST_HALTED;
          r_halted      <= 1'b1;
          r_valid_d1    <= 1'b0;
          r_instr_valid <= 1'b0;
        end
        ACT_HOLD: begin
          r_valid_d1    <= 1'b0;
          r_instr_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign address     = r_address;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;
  assign opcode      = w_opcode;
  assign dest        = r_instr[DST_HI:DST_LO];
  assign imm         = r_instr[IMM_HI:IMM_LO];
  assign halted      = r_halted;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: synchronous program-memory model,
// in-order scoreboard of consumed IR words, branch/wrap vector table, and
// hand sequences for stall, HALT and reset corners.
module tb_instr_fetch;

  localparam int AW = 10;
  localparam int IW = 22;
  localparam logic [IW-1:0] HALT_WORD = {4'hF, 6'b0, 3'b101, 9'h0AB};

  logic          clock = 1'b0;
  logic          PC_Reset;
  logic [IW-1:0] RAMdata;
  logic [AW-1:0] address;
  logic          stall;
  logic          branch_taken;
  logic [AW-1:0] branch_target;
  logic [IW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic [3:0]    opcode;
  logic [2:0]    dest;
  logic [8:0]    imm;
  logic          halted;

  int n_checks = 0;
  int n_fail   = 0;

  logic          halt_en = 1'b0;
  logic          sb_on   = 1'b0;
  logic [AW-1:0] sb_q[$];

  typedef struct {
    logic          stall;
    logic          br;
    logic [AW-1:0] tgt;
    logic [AW-1:0] exp_addr;
    logic          exp_valid;
    logic [AW-1:0] exp_pc;
  } vec_t;

  vec_t br_tab[12];

  instr_fetch dut (
    .clock         (clock),
    .PC_Reset      (PC_Reset),
    .RAMdata       (RAMdata),
    .address       (address),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .opcode        (opcode),
    .dest          (dest),
    .imm           (imm),
    .halted        (halted)
  );

  always #5 clock = ~clock;

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a, input logic hen);
    if (hen && a == AW'(12)) return HALT_WORD;
    return {{(IW-AW){1'b0}}, a};
  endfunction

  always @(posedge clock) RAMdata <= mem_word(address, halt_en);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pops the scoreboard when the current IR is consumed at the coming edge.
  task automatic step();
    logic [AW-1:0] e;
    if (sb_on && instr_valid && !stall) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        check("sb_pc", 32'(instr_pc), 32'(e));
        check("sb_instr", 32'(instr), 32'(e));
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_addr"},   32'(address),     32'd0);
    check({tag, "_instr"},  32'(instr),       32'd0);
    check({tag, "_ipc"},    32'(instr_pc),    32'd0);
    check({tag, "_valid"},  32'(instr_valid), 32'd0);
    check({tag, "_halted"}, 32'(halted),      32'd0);
  endtask

  initial begin
    logic [AW-1:0] p;

    br_tab[0]  = '{1'b0, 1'b1, 10'h3F0, 10'h3F0, 1'b0, 10'h000};
    br_tab[1]  = '{1'b0, 1'b0, 10'h000, 10'h3F1, 1'b0, 10'h000};
    br_tab[2]  = '{1'b0, 1'b0, 10'h000, 10'h3F2, 1'b1, 10'h3F0};
    br_tab[3]  = '{1'b0, 1'b0, 10'h000, 10'h3F3, 1'b1, 10'h3F1};
    br_tab[4]  = '{1'b1, 1'b1, 10'h100, 10'h3F2, 1'b1, 10'h3F1};
    br_tab[5]  = '{1'b0, 1'b0, 10'h000, 10'h3F3, 1'b0, 10'h000};
    br_tab[6]  = '{1'b0, 1'b0, 10'h000, 10'h3F4, 1'b1, 10'h3F2};
    br_tab[7]  = '{1'b0, 1'b1, 10'h3FE, 10'h3FE, 1'b0, 10'h000};
    br_tab[8]  = '{1'b0, 1'b1, 10'h200, 10'h3FF, 1'b0, 10'h000};
    br_tab[9]  = '{1'b0, 1'b0, 10'h000, 10'h000, 1'b1, 10'h3FE};
    br_tab[10] = '{1'b0, 1'b0, 10'h000, 10'h001, 1'b1, 10'h3FF};
    br_tab[11] = '{1'b0, 1'b0, 10'h000, 10'h002, 1'b1, 10'h000};

    PC_Reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;

    // Reset held: address stays 0.
    for (int i = 0; i < 3; i++) begin
      step();
      check_reset("reset");
    end

    // Free run from reset with in-order scoreboard.
    for (int k = 0; k < 8; k++) sb_q.push_back(AW'(k));
    PC_Reset = 1'b0;
    sb_on = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      check("run_addr", 32'(address), 32'(k));
      check("run_valid", 32'(instr_valid), (k >= 2) ? 32'd1 : 32'd0);
      if (k == 2) begin
        check("first_ipc", 32'(instr_pc), 32'd0);
        check("first_instr", 32'(instr), 32'd0);
      end
    end

    // Stall three cycles with IR at pc 5.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_addr", 32'(address), 32'd6);
      check("stall_ipc", 32'(instr_pc), 32'd5);
      check("stall_instr", 32'(instr), 32'd5);
      check("stall_valid", 32'(instr_valid), 32'd1);
    end
    stall = 1'b0;
    step();
    check("bubble_valid", 32'(instr_valid), 32'd0);
    check("bubble_addr", 32'(address), 32'd7);
    for (int k = 8; k <= 10; k++) begin
      step();
      check("post_stall_addr", 32'(address), 32'(k));
      check("post_stall_valid", 32'(instr_valid), 32'd1);
    end
    sb_on = 1'b0;
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("pre_branch_ipc", 32'(instr_pc), 32'd8);

    // Branch, stall-masked branch, invalid-IR branch and address wrap.
    for (int r = 0; r < 12; r++) begin
      stall = br_tab[r].stall;
      branch_taken = br_tab[r].br;
      branch_target = br_tab[r].tgt;
      step();
      check($sformatf("tab%0d_addr", r), 32'(address), 32'(br_tab[r].exp_addr));
      check($sformatf("tab%0d_valid", r), 32'(instr_valid), 32'(br_tab[r].exp_valid));
      if (br_tab[r].exp_valid) begin
        p = br_tab[r].exp_pc;
        check($sformatf("tab%0d_ipc", r), 32'(instr_pc), 32'(p));
        check($sformatf("tab%0d_instr", r), 32'(instr), 32'(p));
        check($sformatf("tab%0d_imm", r), 32'(imm), 32'(p[8:0]));
        check($sformatf("tab%0d_dest", r), 32'(dest), 32'(p[9]));
      end
    end
    stall = 1'b0; branch_taken = 1'b0; branch_target = '0;

    // HALT at pc 12, with a simultaneous branch request.
    halt_en = 1'b1;
    PC_Reset = 1'b1;
    step();
    check_reset("halt_pre_reset");
    PC_Reset = 1'b0;
    for (int k = 1; k <= 14; k++) step();
    check("halt_pre_addr", 32'(address), 32'd14);
    check("halt_pre_ipc", 32'(instr_pc), 32'd12);
    check("halt_pre_opc", 32'(opcode), 32'hF);
    branch_taken = 1'b1; branch_target = 10'h055;
    step();
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_addr", 32'(address), 32'd14);
    check("halt_valid", 32'(instr_valid), 32'd0);
    check("halt_instr", 32'(instr), 32'(HALT_WORD));
    check("halt_dest", 32'(dest), 32'd5);
    check("halt_imm", 32'(imm), 32'h0AB);
    step();
    branch_taken = 1'b0; stall = 1'b1;
    step();
    stall = 1'b0;
    step();
    check("halted_addr", 32'(address), 32'd14);
    check("halted_flag", 32'(halted), 32'd1);
    check("halted_valid", 32'(instr_valid), 32'd0);
    PC_Reset = 1'b1;
    step();
    check_reset("halt_reset");
    PC_Reset = 1'b0;
    halt_en = 1'b0;
    step();
    check("halt_release_addr", 32'(address), 32'd1);

    // Reset arriving mid-stall.
    for (int k = 2; k <= 5; k++) step();
    stall = 1'b1;
    step();
    check("mid_stall_addr", 32'(address), 32'd4);
    PC_Reset = 1'b1;
    step();
    check_reset("reset_in_stall");
    PC_Reset = 1'b0; stall = 1'b0;

    // Reset arriving together with a branch.
    for (int k = 1; k <= 4; k++) step();
    check("pre_rb_valid", 32'(instr_valid), 32'd1);
    branch_taken = 1'b1; branch_target = 10'h123; PC_Reset = 1'b1;
    step();
    check_reset("reset_in_branch");
    branch_taken = 1'b0; PC_Reset = 1'b0;
    step();
    check("final_addr", 32'(address), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; reset samples only on posedge clock.
REQ-002 Parameter ADDR_W, 10, instruction address width (1024-word program space).
REQ-003 Parameter INSTR_W, 22, instruction word width.
REQ-004 clock  in  1  sole clock; all state updates on posedge.
REQ-005 PC_Reset  in  1  synchronous active-high reset, driven by program memory.
REQ-006 RAMdata  in  INSTR_W  instruction word; equals mem[address sampled at previous posedge].
REQ-007 address  out  ADDR_W  registered fetch PC presented to program memory.
REQ-008 stall  in  1  downstream not consuming current IR this cycle.
REQ-009 branch_taken  in  1  redirect request for the instruction in IR.
REQ-010 branch_target  in  ADDR_W  redirect address.
REQ-011 instr  out  INSTR_W  registered instruction register (IR).
REQ-012 instr_pc  out  ADDR_W  address the IR word was fetched from.
REQ-013 instr_valid  out  1  IR holds a consumable instruction.
REQ-014 opcode/dest/imm  out  4/3/9  IR[21:18], IR[11:9], IR[8:0].
REQ-015 halted  out  1  sticky HALT-reached flag.

Function
REQ-016 Internal stage D1 SHALL hold pc_d1 (address of word on RAMdata) and valid_d1.
REQ-017 Two states, RUN and HALTED; edge priority SHALL be PC_Reset > HALT > stall > branch > advance.
REQ-018 Advance (RUN, no stall/branch/HALT): IR<=RAMdata, instr_pc<=pc_d1, instr_valid<=valid_d1, pc_d1<=address, valid_d1<=1, address<=address+1.
REQ-019 Fetch-to-IR latency SHALL be 2 cycles; one new address per cycle with no stall or branch.
REQ-020 address SHALL wrap 1023 -> 0 silently.
REQ-021 Stall: IR, instr_pc, instr_valid held; address<=pc_d1 if valid_d1 else held; valid_d1<=0 (RAMdata word dropped, then replayed).
REQ-022 Consecutive stall cycles SHALL keep address constant; release costs exactly one IR bubble.
REQ-023 branch_taken SHALL take effect only when instr_valid=1 and stall=0; otherwise ignored.
REQ-024 Branch: address<=branch_target, valid_d1<=0, instr_valid<=0 (wrong-path word squashed); target reaches IR 2 cycles later.
REQ-025 HALT: instr_valid=1 and opcode=4'hF (stall irrelevant) SHALL enter HALTED next edge.
REQ-026 HALTED: halted=1, address frozen, valid_d1=0, instr_valid=0, IR retains the HALT word; stall and branch ignored.
REQ-027 HALT and branch_taken in the same cycle: HALT wins, address not redirected.

Reset
REQ-028 PC_Reset=1 at an edge SHALL set address=0, pc_d1=0, valid_d1=0, IR=0, instr_pc=0, instr_valid=0, halted=0, state=RUN, overriding any activity including HALTED.
REQ-029 While PC_Reset is held, address SHALL stay 0; first post-reset edge advances to 1.

Structure
REQ-030 Shared package fetch_pkg SHALL hold ADDR_W, INSTR_W, OP_HALT=4'hF, field bit positions (opcode 21:18, dest 11:9, imm 8:0) and the RUN/HALTED enum.
REQ-031 Next-PC selection SHALL be one combinational sub-module, fetch_pc_sel; all registers live in instr_fetch.

Verification
REQ-032 Reset then free-run with mem[k]=k: address 0,1,2,... per cycle; instr_valid first high 2 cycles after reset release with instr_pc=0, instr=0.
REQ-033 Stall 3 cycles while instr_pc=5: IR holds word 5; address holds 6 throughout; after release IR shows bubble, then 6,7,... with no gap or duplicate.
REQ-034 branch_taken with IR at pc 8, target 0x3F0: next-cycle address=0x3F0, instr_valid=0 for 2 cycles, then instr_pc=0x3F0.
REQ-035 mem[12]=opcode 4'hF: halted=1 the edge after instr_pc=12 is valid; address frozen; branch/stall pulses change nothing; PC_Reset restores address=0, halted=0.
REQ-036 Start at target 1022 via branch: addresses 1022,1023,0,1; instr_pc follows 1022,1023,0.
REQ-037 PC_Reset asserted mid-stall and mid-branch: all outputs take REQ-028 values at that edge.
